// File: rtl/image_stream_capture.sv
// Receiving end of the dual-pixel sensor video interface: checks frame and line timing,
// tags each pixel pair with its row and column, and streams pairs out through a small FWFT FIFO.
module image_stream_capture #(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int FIFO_DEPTH = 4,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 10
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             VSYNC,
    input  logic             HSYNC,
    input  logic [7:0]       DATA_R0,
    input  logic [7:0]       DATA_G0,
    input  logic [7:0]       DATA_B0,
    input  logic [7:0]       DATA_R1,
    input  logic [7:0]       DATA_G1,
    input  logic [7:0]       DATA_B1,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [47:0]      m_data,
    output logic [ROW_W-1:0] m_row,
    output logic [COL_W-1:0] m_col,
    output logic             m_sof,
    output logic             m_eol,
    output logic             frame_done,
    output logic             err_ovf,
    output logic             err_line,
    output logic             err_frame,
    input  logic             err_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Counters carry one extra bit so col can rest at WIDTH and row can reach HEIGHT.
    localparam logic [COL_W:0] COL_END  = (COL_W + 1)'(WIDTH);
    localparam logic [COL_W:0] COL_LAST = (COL_W + 1)'(WIDTH - 2);
    localparam logic [COL_W:0] COL_STEP = (COL_W + 1)'(2);
    localparam logic [ROW_W:0] ROW_END  = (ROW_W + 1)'(HEIGHT);
    localparam logic [ROW_W:0] ROW_STEP = (ROW_W + 1)'(1);
    localparam logic [PTR_W:0] PTR_STEP = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] PTR_WRAP = {1'b1, {PTR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    typedef struct packed {
        logic [47:0]      data;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             sof;
        logic             eol;
    } entry_t;

    logic           vs_q, vs_q2, hs_q, hs_q2;
    logic [47:0]    data_q;
    state_t         state;
    logic [ROW_W:0] row;
    logic [COL_W:0] col;
    logic           restart, line_end, pair_in;
    logic           vs_rise, hs_fall, at_origin;
    logic           push_req, push, pop, full, set_ovf, set_line;
    logic [PTR_W:0] wr_ptr, rd_ptr;
    entry_t         mem [FIFO_DEPTH];
    entry_t         new_entry, head;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            vs_q   <= 1'b0;
            vs_q2  <= 1'b0;
            hs_q   <= 1'b0;
            hs_q2  <= 1'b0;
            data_q <= '0;
        end else begin
            // NOTE: non-blocking so vs_q2 takes the old vs_q, forming a true two-stage pipe.
            vs_q   <= VSYNC;
            vs_q2  <= vs_q;
            hs_q   <= HSYNC;
            hs_q2  <= hs_q;
            data_q <= {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1};
        end
    end

    assign vs_rise   = vs_q & ~vs_q2;
    assign hs_fall   = ~hs_q & hs_q2;
    assign at_origin = (row == '0) && (col == '0);

    // A restarting VSYNC outranks line events; a falling HSYNC and a pair are exclusive.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        restart  = 1'b0;
        line_end = 1'b0;
        pair_in  = 1'b0;
        if (state == ACTIVE) begin
            if (vs_rise && !at_origin) restart  = 1'b1;
            else if (hs_fall)          line_end = 1'b1;
            else if (hs_q)             pair_in  = 1'b1;
        end
    end

    assign push_req = pair_in && (col < COL_END);
    assign pop      = m_valid && m_ready;
    assign full     = (wr_ptr ^ rd_ptr) == PTR_WRAP;
    assign push     = push_req && (!full || pop);
    assign set_ovf  = push_req && full && !pop;
    assign set_line = (pair_in && (col >= COL_END)) || (line_end && (col != COL_END));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (vs_rise) begin
                        state <= ACTIVE;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                ACTIVE: begin
                    if (restart) begin
                        row <= '0;
                        col <= '0;
                    end else if (line_end) begin
                        col <= '0;
                        if (row + ROW_STEP == ROW_END) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            row <= row + ROW_STEP;
                        end
                    end else if (push_req) begin
                        // Column advances even when the FIFO drops the pair.
                        col <= col + COL_STEP;
                    end
                end
                DONE: begin
                    if (vs_rise) begin
                        state <= ACTIVE;
                        row   <= '0;
                        col   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_ovf   <= 1'b0;
            err_line  <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            err_ovf   <= set_ovf  | (err_ovf   & ~err_clr);
            err_line  <= set_line | (err_line  & ~err_clr);
            err_frame <= restart  | (err_frame & ~err_clr);
        end
    end

    assign new_entry = '{data: data_q,
                         row:  row[ROW_W-1:0],
                         col:  col[COL_W-1:0],
                         sof:  at_origin,
                         eol:  col == COL_LAST};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_STEP;
            if (pop)  rd_ptr <= rd_ptr + PTR_STEP;
        end
    end

    // NOTE: storage is not reset; the outputs are gated by m_valid so stale entries never leak.
    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= new_entry;
    end

    assign head    = mem[rd_ptr[PTR_W-1:0]];
    assign m_valid = (wr_ptr != rd_ptr);
    assign m_data  = m_valid ? head.data : '0;
    assign m_row   = m_valid ? head.row  : '0;
    assign m_col   = m_valid ? head.col  : '0;
    assign m_sof   = m_valid & head.sof;
    assign m_eol   = m_valid & head.eol;

endmodule

// File: tb/tb_image_stream_capture.sv
// Randomised self-checking bench for image_stream_capture against a queue-based reference model.
module tb_image_stream_capture;

    localparam int W = 8;
    localparam int H = 4;
    localparam int D = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn, VSYNC, HSYNC, m_ready, err_clr;
    logic [7:0]  DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
    logic        m_valid, m_sof, m_eol, frame_done, err_ovf, err_line, err_frame;
    logic [47:0] m_data;
    logic [9:0]  m_row, m_col;

    image_stream_capture #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D), .COL_W(10), .ROW_W(10)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC),
        .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
        .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row), .m_col(m_col),
        .m_sof(m_sof), .m_eol(m_eol), .frame_done(frame_done),
        .err_ovf(err_ovf), .err_line(err_line), .err_frame(err_frame), .err_clr(err_clr)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [47:0] data;
        int          row;
        int          col;
        bit          sof;
        bit          eol;
    } ent_t;

    int checks = 0, failures = 0;
    int cyc = 0, fall_cyc = 0, fd_cyc = -100, n_done = 0;
    int ready_mode = 0;
    bit rand_clr = 0;
    logic [47:0] line_first;
    ent_t got[$];

    // Reference model: registered-input view, frame/line position and an ideal bounded queue.
    ent_t        q[$];
    bit          r_vs, r_hs, p_vs, p_hs, f_ovf, f_line, f_frm, f_done;
    logic [47:0] r_data;
    int          phase, row, col;   // phase: 0 waiting for frame, 1 in frame, 2 frame just ended

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        {r_vs, r_hs, p_vs, p_hs, f_ovf, f_line, f_frm, f_done} = '0;
        r_data = '0;
        phase = 0; row = 0; col = 0;
    endtask

    task automatic model_step();
        bit   vs_rise, hs_fall, pop, push, s_line, s_frm, s_ovf;
        int   n;
        ent_t e;
        vs_rise = r_vs && !p_vs;
        hs_fall = !r_hs && p_hs;
        pop     = (q.size() != 0) && m_ready;
        {push, s_line, s_frm, s_ovf, f_done} = '0;
        e = '{default: 0};
        if (phase == 1) begin
            if (vs_rise && (row != 0 || col != 0)) begin
                s_frm = 1; row = 0; col = 0;
            end else if (hs_fall) begin
                if (col != W) s_line = 1;
                row++; col = 0;
                if (row == H) begin phase = 2; f_done = 1; end
            end else if (r_hs) begin
                if (col < W) begin
                    e = '{data: r_data, row: row, col: col, sof: (row == 0 && col == 0), eol: (col == W - 2)};
                    push = 1; col += 2;
                end else s_line = 1;
            end
        end else if (vs_rise) begin
            phase = 1; row = 0; col = 0;
        end else begin
            phase = 0;
        end
        n = q.size();
        if (pop) void'(q.pop_front());
        if (push) begin
            if (n < D || pop) q.push_back(e);
            else s_ovf = 1;
        end
        f_ovf  = s_ovf  || (f_ovf  && !err_clr);
        f_line = s_line || (f_line && !err_clr);
        f_frm  = s_frm  || (f_frm  && !err_clr);
        p_vs = r_vs; p_hs = r_hs;
        r_vs = VSYNC; r_hs = HSYNC;
        r_data = {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1};
    endtask

    task automatic compare();
        check("m_valid", m_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("m_data", m_data, q[0].data);
            check("m_row", m_row, q[0].row);
            check("m_col", m_col, q[0].col);
            check("m_sof", m_sof, q[0].sof);
            check("m_eol", m_eol, q[0].eol);
        end
        check("frame_done", frame_done, f_done);
        check("err_ovf", err_ovf, f_ovf);
        check("err_line", err_line, f_line);
        check("err_frame", err_frame, f_frm);
    endtask

    task automatic cycle();
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
        if (rand_clr) err_clr = ($urandom_range(0, 15) == 0);
        @(negedge HCLK);
        compare();
        if (m_valid && m_ready)
            got.push_back('{data: m_data, row: int'(m_row), col: int'(m_col), sof: m_sof, eol: m_eol});
        if (frame_done) begin n_done++; fd_cyc = cyc; end
        @(posedge HCLK);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic rand_data();
        DATA_R0 = 8'($urandom); DATA_G0 = 8'($urandom); DATA_B0 = 8'($urandom);
        DATA_R1 = 8'($urandom); DATA_G1 = 8'($urandom); DATA_B1 = 8'($urandom);
    endtask

    task automatic send_line(input int npairs, input int gap);
        for (int i = 0; i < npairs; i++) begin
            HSYNC = 1'b1;
            rand_data();
            if (i == 0) line_first = {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1};
            cycle();
        end
        HSYNC = 1'b0;
        fall_cyc = cyc;
        for (int i = 0; i < gap; i++) cycle();
    endtask

    task automatic vsync_pulse();
        HSYNC = 1'b0;
        VSYNC = 1'b1; cycle(); cycle();
        VSYNC = 1'b0; cycle();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1; cycle();
        err_clr = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_data"}, m_data, 0);
        check({tag, "_rowcol"}, {m_row, m_col}, 0);
        check({tag, "_flags"}, {m_sof, m_eol, frame_done, err_ovf, err_line, err_frame}, 0);
    endtask

    task automatic release_reset();
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        model_step();
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        HRESETn = 1'b0; VSYNC = 1'b0; HSYNC = 1'b0; m_ready = 1'b1; err_clr = 1'b0;
        rand_data();
        model_reset();
        #1;
        check_outputs_zero("reset");
        @(posedge HCLK);
        release_reset();
        repeat (3) cycle();

        // Nominal frame with downstream always ready.
        ready_mode = 0; got.delete(); n_done = 0;
        vsync_pulse();
        for (int l = 0; l < H; l++) send_line(W / 2, 2);
        repeat (4) cycle();
        check("nom_count", got.size(), H * W / 2);
        for (int i = 0; i < got.size(); i++) begin
            check("nom_pos", {got[i].row, got[i].col}, {i / (W / 2), (i % (W / 2)) * 2});
            check("nom_sof_eol", {got[i].sof, got[i].eol}, {i == 0, (i % (W / 2)) == W / 2 - 1});
        end
        check("nom_done_count", n_done, 1);
        check("nom_done_lat", fd_cyc - fall_cyc, 2);
        check("nom_errs", {err_ovf, err_line, err_frame}, 0);

        // Backpressure: a whole line held, then the next line's first pair overflows.
        vsync_pulse();
        send_line(W / 2, 2);
        ready_mode = 2; got.delete();
        send_line(W / 2, 2);
        check("bp_hold_data", m_data, line_first);
        cycle(); cycle();
        check("bp_hold_stable", m_data, line_first);
        check("bp_hold_pos", {m_valid, m_row, m_col}, {1'b1, 10'd1, 10'd0});
        HSYNC = 1'b1; rand_data(); cycle();
        rand_data(); cycle();
        ready_mode = 0;
        rand_data(); cycle();
        rand_data(); cycle();
        HSYNC = 1'b0; cycle(); cycle();
        check("bp_ovf", err_ovf, 1);
        repeat (6) cycle();
        check("bp_count", got.size(), W / 2 + W / 2 - 1);
        check("bp_row_adv", got[got.size() - 1].row, 2);
        send_line(W / 2, 4);
        pulse_clr();
        check("clr_flags", {err_ovf, err_line, err_frame}, 0);

        // Short line followed by a normal one.
        got.delete();
        vsync_pulse();
        send_line(W / 2 - 1, 2);
        send_line(W / 2, 3);
        check("short_err", err_line, 1);
        check("short_next", {got[W / 2 - 1].row, got[W / 2 - 1].col}, {1, 0});
        send_line(W / 2, 2); send_line(W / 2, 4);
        pulse_clr();

        // Long line: the extra pair is discarded.
        got.delete();
        vsync_pulse();
        send_line(W / 2 + 1, 4);
        check("long_err", err_line, 1);
        check("long_count", got.size(), W / 2);
        for (int l = 1; l < H; l++) send_line(W / 2, 2);
        repeat (3) cycle();
        pulse_clr();

        // Early VSYNC at row 2, col 4 restarts the frame.
        n_done = 0;
        vsync_pulse();
        send_line(W / 2, 2); send_line(W / 2, 2);
        HSYNC = 1'b1; rand_data(); cycle(); rand_data(); cycle();
        HSYNC = 1'b0; VSYNC = 1'b1; cycle(); cycle();
        VSYNC = 1'b0; cycle();
        check("early_err", err_frame, 1);
        cycle(); cycle();
        got.delete();
        for (int l = 0; l < H; l++) send_line(W / 2, 2);
        repeat (4) cycle();
        check("early_first", {got[0].row, got[0].col, 31'd0, got[0].sof}, {32'd0, 32'd1});
        check("early_done_count", n_done, 1);
        pulse_clr();

        // Randomised frames: random ready, gaps, line lengths and clear pulses.
        ready_mode = 1; rand_clr = 1;
        for (int f = 0; f < 10; f++) begin
            vsync_pulse();
            for (int l = 0; l < H; l++) begin
                int sel;
                sel = $urandom_range(0, 9);
                send_line((sel == 0) ? W / 2 - 1 : (sel == 1) ? W / 2 + 1 : W / 2, $urandom_range(1, 3));
            end
            repeat ($urandom_range(0, 2)) cycle();
        end
        rand_clr = 0; err_clr = 1'b0;
        repeat (8) cycle();

        // Reset mid-line with entries buffered; pairs before a fresh VSYNC are ignored.
        ready_mode = 2;
        vsync_pulse();
        HSYNC = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_data(); cycle(); end
        HRESETn = 1'b0;
        #1;
        check_outputs_zero("midrst");
        model_reset();
        @(posedge HCLK);
        release_reset();
        ready_mode = 0; got.delete();
        for (int i = 0; i < 6; i++) begin rand_data(); cycle(); end
        HSYNC = 1'b0;
        repeat (3) cycle();
        check("post_rst_count", got.size(), 0);
        check("post_rst_valid", m_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
